// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller: bus map offsets and FSM encodings.
package irq_controller_pkg;

   localparam logic [63:0] IRQ_BASE  = 64'h0000_0000_0000_3000;
   localparam logic [1:0]  IRQ_PEND  = 2'd0;
   localparam logic [1:0]  IRQ_EN    = 2'd1;
   localparam logic [1:0]  IRQ_CLAIM = 2'd2;
   localparam logic [1:0]  IRQ_GIE   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ASSERT = 2'd1,
      ST_DRAIN  = 2'd2
   } irq_state_t;

endpackage

// File: rtl/irq_controller_sync_edge.sv
// Per-source synchroniser: delivers the synced level and a one-cycle registered rise pulse.
module irq_sync_edge
   import irq_controller_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic irq_in,
   output logic level,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   prev_reg;
   logic                   rise_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_reg <= '0;
         prev_reg <= 1'b0;
         rise_reg <= 1'b0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], irq_in};
         prev_reg <= sync_reg[SYNC_STAGES-1];
         rise_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
      end
   end

   assign level = sync_reg[SYNC_STAGES-1];
   assign rise  = rise_reg;

endmodule

// File: rtl/irq_controller.sv
// Fixed-priority interrupt controller: latches one vector for the core and holds it until acked.
module irq_controller
   import irq_controller_pkg::*;
#(
   parameter int                 NUM_SRC     = 4,
   parameter int                 VEC_W       = 4,
   parameter logic [NUM_SRC-1:0] EDGE_MASK   = {NUM_SRC{1'b1}},
   parameter int                 SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic               sel,
   input  logic [1:0]         reg_addr,
   input  logic [63:0]        bus_write_data,
   input  logic               bus_write_enable,
   input  logic               bus_read_enable,
   output logic [63:0]        bus_read_data,
   output logic [VEC_W-1:0]   interrupt_vector,
   input  logic               interrupt_ack,
   output logic               irq_pending_any
);

   genvar gi;

   logic [NUM_SRC-1:0] s_level;
   logic [NUM_SRC-1:0] s_rise;
   logic [NUM_SRC-1:0] pending_reg;
   logic [NUM_SRC-1:0] pending_next;
   logic [NUM_SRC-1:0] enable_reg;
   logic               gie_reg;
   irq_state_t         state_reg;
   logic [NUM_SRC-1:0] w1c_mask;
   logic [NUM_SRC-1:0] ack_clr;
   logic               wr_hit;
   logic               rd_hit;
   logic               irq_ready;
   logic               claim_done;
   logic               unused_wdata;

   function automatic logic [VEC_W-1:0] prio_vec(input logic [NUM_SRC-1:0] req);
      prio_vec = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) prio_vec = VEC_W'(i + 1);
      end
   endfunction

   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_sync
         irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .reset  (reset),
            .irq_in (irq_src[gi]),
            .level  (s_level[gi]),
            .rise   (s_rise[gi])
         );
      end
   endgenerate

   assign wr_hit       = sel & bus_write_enable;
   assign rd_hit       = sel & bus_read_enable;
   assign irq_ready    = gie_reg & |(pending_reg & enable_reg);
   assign claim_done   = (state_reg == ST_ASSERT) & interrupt_ack;
   assign w1c_mask     = (wr_hit && reg_addr == IRQ_PEND) ? bus_write_data[NUM_SRC-1:0] : '0;
   assign unused_wdata = ^bus_write_data[63:NUM_SRC];

   // Edge sources: a fresh rise beats any clear landing in the same cycle.
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_pend
         assign ack_clr[gi] = claim_done & (interrupt_vector == VEC_W'(gi + 1));
         if (EDGE_MASK[gi]) begin : g_edge
            assign pending_next[gi] = s_rise[gi] | (pending_reg[gi] & ~(w1c_mask[gi] | ack_clr[gi]));
         end else begin : g_level
            assign pending_next[gi] = s_level[gi];
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_reg     <= '0;
         enable_reg      <= '0;
         gie_reg         <= 1'b0;
         irq_pending_any <= 1'b0;
         bus_read_data   <= '0;
      end else begin
         pending_reg     <= pending_next;
         irq_pending_any <= |(pending_reg & enable_reg);
         if (wr_hit && reg_addr == IRQ_EN)  enable_reg <= bus_write_data[NUM_SRC-1:0];
         if (wr_hit && reg_addr == IRQ_GIE) gie_reg    <= bus_write_data[0];
         if (rd_hit) begin
            case (reg_addr)
               IRQ_PEND:  bus_read_data <= 64'(pending_reg);
               IRQ_EN:    bus_read_data <= 64'(enable_reg);
               IRQ_CLAIM: bus_read_data <= 64'(interrupt_vector);
               default:   bus_read_data <= 64'(gie_reg);
            endcase
         end
      end
   end

   // DRAIN keeps a long ack from the slower core clock from claiming a second source.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg        <= ST_IDLE;
         interrupt_vector <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (irq_ready && !interrupt_ack) begin
                  state_reg        <= ST_ASSERT;
                  interrupt_vector <= prio_vec(pending_reg & enable_reg);
               end
            end
            ST_ASSERT: begin
               if (interrupt_ack) begin
                  state_reg        <= ST_DRAIN;
                  interrupt_vector <= '0;
               end
            end
            ST_DRAIN: begin
               if (!interrupt_ack) state_reg <= ST_IDLE;
            end
            default: begin
               state_reg        <= ST_IDLE;
               interrupt_vector <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench: two controllers (all-edge and src0-level), expectations queued at stimulus time.
module tb_irq_controller;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #10 clk = ~clk;

   logic [3:0]  a_src = '0, b_src = '0;
   logic        a_sel = 0, a_we = 0, a_re = 0, a_ack = 0;
   logic        b_sel = 0, b_we = 0, b_re = 0, b_ack = 0;
   logic [1:0]  a_addr = '0, b_addr = '0;
   logic [63:0] a_wdata = '0, b_wdata = '0;
   logic [63:0] a_rdata, b_rdata;
   logic [3:0]  a_vec, b_vec;
   logic        a_any, b_any;

   irq_controller dut_a (
      .clk(clk), .reset(rst), .irq_src(a_src), .sel(a_sel), .reg_addr(a_addr),
      .bus_write_data(a_wdata), .bus_write_enable(a_we), .bus_read_enable(a_re),
      .bus_read_data(a_rdata), .interrupt_vector(a_vec), .interrupt_ack(a_ack),
      .irq_pending_any(a_any)
   );

   irq_controller #(.EDGE_MASK(4'b1110)) dut_b (
      .clk(clk), .reset(rst), .irq_src(b_src), .sel(b_sel), .reg_addr(b_addr),
      .bus_write_data(b_wdata), .bus_write_enable(b_we), .bus_read_enable(b_re),
      .bus_read_data(b_rdata), .interrupt_vector(b_vec), .interrupt_ack(b_ack),
      .irq_pending_any(b_any)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] exp_rd_a[$];
   logic [63:0] exp_rd_b[$];
   logic [3:0]  exp_vec_a[$];
   logic [3:0]  exp_vec_b[$];

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end else begin
         $display("ok   %s: %0h (t=%0t)", name, act, $time);
      end
   endtask

   task automatic miss(input string name, input logic [63:0] act);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %0h, expected no event (t=%0t)", name, act, $time);
   endtask

   // Monitors: one read response per strobe, one queued expectation per vector change.
   logic       rd_due_a = 0, rd_due_b = 0;
   logic [3:0] last_vec_a = '0, last_vec_b = '0;

   always @(negedge clk) begin : mon_a
      if (rst) begin
         rd_due_a   = 1'b0;
         last_vec_a = a_vec;
      end else begin
         if (rd_due_a) begin
            if (exp_rd_a.size() == 0) miss("A_read", a_rdata);
            else cmp("A_read", a_rdata, exp_rd_a.pop_front());
         end
         rd_due_a = a_sel & a_re;
         if (a_vec !== last_vec_a) begin
            if (exp_vec_a.size() == 0) miss("A_vector", a_vec);
            else cmp("A_vector", a_vec, exp_vec_a.pop_front());
            last_vec_a = a_vec;
         end
      end
   end

   always @(negedge clk) begin : mon_b
      if (rst) begin
         rd_due_b   = 1'b0;
         last_vec_b = b_vec;
      end else begin
         if (rd_due_b) begin
            if (exp_rd_b.size() == 0) miss("B_read", b_rdata);
            else cmp("B_read", b_rdata, exp_rd_b.pop_front());
         end
         rd_due_b = b_sel & b_re;
         if (b_vec !== last_vec_b) begin
            if (exp_vec_b.size() == 0) miss("B_vector", b_vec);
            else cmp("B_vector", b_vec, exp_vec_b.pop_front());
            last_vec_b = b_vec;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input bit b, input logic [1:0] addr, input logic [63:0] d);
      if (!b) begin a_sel = 1; a_we = 1; a_addr = addr; a_wdata = d; end
      else    begin b_sel = 1; b_we = 1; b_addr = addr; b_wdata = d; end
      step();
      a_sel = 0; a_we = 0; b_sel = 0; b_we = 0;
   endtask

   task automatic bus_read(input bit b, input logic [1:0] addr, input logic [63:0] exp);
      if (!b) begin exp_rd_a.push_back(exp); a_sel = 1; a_re = 1; a_addr = addr; end
      else    begin exp_rd_b.push_back(exp); b_sel = 1; b_re = 1; b_addr = addr; end
      step();
      a_sel = 0; a_re = 0; b_sel = 0; b_re = 0;
   endtask

   task automatic wait_vec(input bit b, input logic [3:0] v, input int budget);
      int n = 0;
      while (((b ? b_vec : a_vec) !== v) && n < budget) begin
         step();
         n++;
      end
      cmp(b ? "B_wait_vector" : "A_wait_vector", b ? b_vec : a_vec, v);
   endtask

   initial begin : watchdog
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int lat;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      cmp("reset_vector", a_vec, 0);
      cmp("reset_rdata", a_rdata, 0);
      cmp("reset_any", a_any, 0);

      // Single edge on src2: latency, pending read, ack drop and no re-claim during ack
      bus_write(0, 2'd1, 64'h5);
      bus_write(0, 2'd3, 64'h1);
      exp_vec_a.push_back(4'd3);
      a_src = 4'b0100;
      step();
      a_src = 4'b0000;
      lat = 0;
      while (a_vec == 4'd0 && lat < 20) begin
         step();
         lat++;
      end
      cmp("edge_latency", lat, 4);
      bus_read(0, 2'd0, 64'h4);
      cmp("any_in_assert", a_any, 1);
      exp_vec_a.push_back(4'd0);
      a_ack = 1;
      step();
      cmp("vector_on_ack", a_vec, 0);
      bus_read(0, 2'd0, 64'h0);
      repeat (8) step();
      a_ack = 0;
      cmp("any_after_ack", a_any, 0);
      repeat (4) step();
      cmp("idle_after_ack", a_vec, 0);

      // src0 and src2 together: priority order 1 then 3
      exp_vec_a.push_back(4'd1);
      exp_vec_a.push_back(4'd0);
      exp_vec_a.push_back(4'd3);
      exp_vec_a.push_back(4'd0);
      a_src = 4'b0101;
      step();
      a_src = 4'b0000;
      wait_vec(0, 4'd1, 20);
      a_ack = 1;
      step();
      step();
      a_ack = 0;
      wait_vec(0, 4'd3, 10);
      a_ack = 1;
      step();
      a_ack = 0;
      repeat (6) step();
      cmp("idle_after_both", a_vec, 0);
      bus_read(0, 2'd0, 64'h0);

      // src1 pending while disabled, then enabled, then gie/enable dropped while asserted
      a_src = 4'b0010;
      step();
      a_src = 4'b0000;
      repeat (8) step();
      cmp("masked_vector", a_vec, 0);
      cmp("masked_any", a_any, 0);
      bus_read(0, 2'd0, 64'h2);
      exp_vec_a.push_back(4'd2);
      bus_write(0, 2'd1, 64'h2);
      wait_vec(0, 4'd2, 10);
      step();
      cmp("any_enabled", a_any, 1);
      bus_write(0, 2'd3, 64'h0);
      repeat (5) step();
      cmp("held_gie_off", a_vec, 2);
      bus_read(0, 2'd2, 64'h2);
      bus_write(0, 2'd1, 64'h0);
      step();
      cmp("held_enable_off", a_vec, 2);
      bus_write(0, 2'd1, 64'h2);
      exp_vec_a.push_back(4'd0);
      a_ack = 1;
      step();
      a_ack = 0;
      repeat (3) step();
      bus_read(0, 2'd3, 64'h0);

      // W1C alone clears; W1C colliding with a new edge loses
      a_src = 4'b0010;
      step();
      a_src = 4'b0000;
      repeat (6) step();
      bus_read(0, 2'd0, 64'h2);
      bus_write(0, 2'd0, 64'h2);
      bus_read(0, 2'd0, 64'h0);
      a_src = 4'b0010;
      step();
      a_src = 4'b0000;
      step();
      step();
      bus_write(0, 2'd0, 64'h2);
      bus_read(0, 2'd0, 64'h2);

      // Level source on dut_b: W1C ignored, re-claims after drain while held
      bus_write(1, 2'd1, 64'h1);
      bus_write(1, 2'd3, 64'h1);
      exp_vec_b.push_back(4'd1);
      exp_vec_b.push_back(4'd0);
      exp_vec_b.push_back(4'd1);
      exp_vec_b.push_back(4'd0);
      b_src = 4'b0001;
      wait_vec(1, 4'd1, 20);
      bus_write(1, 2'd0, 64'h1);
      bus_read(1, 2'd0, 64'h1);
      b_ack = 1;
      repeat (3) step();
      b_ack = 0;
      wait_vec(1, 4'd1, 10);
      b_src = 4'b0000;
      repeat (6) step();
      cmp("level_held", b_vec, 1);
      b_ack = 1;
      step();
      b_ack = 0;
      repeat (8) step();
      cmp("level_idle", b_vec, 0);
      bus_read(1, 2'd0, 64'h0);

      // Asynchronous reset while asserting vector 2
      exp_vec_a.push_back(4'd2);
      bus_write(0, 2'd3, 64'h1);
      wait_vec(0, 4'd2, 10);
      bus_read(0, 2'd1, 64'h2);
      step();
      cmp("any_before_reset", a_any, 1);
      #4 rst = 1'b1;
      #1;
      cmp("async_reset_vector", a_vec, 0);
      cmp("async_reset_rdata", a_rdata, 0);
      cmp("async_reset_any", a_any, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      bus_read(0, 2'd0, 64'h0);
      bus_read(0, 2'd1, 64'h0);
      bus_read(0, 2'd2, 64'h0);
      bus_read(0, 2'd3, 64'h0);
      repeat (3) step();

      cmp("sb_vec_a_left", exp_vec_a.size(), 0);
      cmp("sb_vec_b_left", exp_vec_b.size(), 0);
      cmp("sb_rd_a_left", exp_rd_a.size(), 0);
      cmp("sb_rd_b_left", exp_rd_b.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Parametrised successor to the single-source keyboard interrupt latch in the board top.
- Collects up to NUM_SRC interrupt sources and synchronises them; each source is edge- or level-sensitive per EDGE_MASK.
- Arbitrates by fixed priority (index 0 highest) and presents one vector at a time to the riscv64 core over the existing interrupt_vector/interrupt_ack pair.
- Bus-mapped pending, enable and global-enable registers sit on the same 64-bit CPU bus as RAM, keyboard and UART.

Parameters:
- NUM_SRC, 4, number of sources. Legal range 1..(2^VEC_W - 1).
- VEC_W, 4, width of interrupt_vector. Value 0 means "no interrupt"; source i is reported as i+1.
- EDGE_MASK, {NUM_SRC{1'b1}}, per source: 1 = rising-edge sensitive, 0 = level sensitive.
- SYNC_STAGES, 2, flop stages on each irq_src bit. Legal range 2..3.

Ports:
- clk, input, 1, system clock (CLOCK_50 domain).
- reset, input, 1, asynchronous, active-high.
- irq_src, input, NUM_SRC, raw source requests, asynchronous to clk.
- sel, input, 1, bus address decode hit for this block.
- reg_addr, input, 2, word offset, taken from bus_address[3:2].
- bus_write_data, input, 64, write data; only [NUM_SRC-1:0] or [0] is used.
- bus_write_enable, input, 1, write strobe; qualified by sel.
- bus_read_enable, input, 1, read strobe; qualified by sel.
- bus_read_data, output, 64, registered read data.
- interrupt_vector, output, VEC_W, current vector; 0 = idle.
- interrupt_ack, input, 1, level from core; high = vector taken.
- irq_pending_any, output, 1, OR of (pending & enable), for the debug LED.

Behaviour:
- Reset values (asynchronous): pending=0, enable=0, gie=0, sync chain=0, prev=0, state=IDLE, interrupt_vector=0, bus_read_data=0, irq_pending_any=0.
- Synchronisation: irq_src passes through SYNC_STAGES flops to give s; prev <= s every cycle.
- Edge source: pending[i] sets on s[i] & ~prev[i].
  - Clears on a W1C bus write, or when its vector is acked.
  - If set and clear land in the same cycle, set wins.
- Level source: pending[i] = s[i] each cycle. W1C and ack have no effect; the device must drop its request.
- Register map (word offsets):
  - 0 PENDING: read returns pending. Write is W1C for edge sources.
  - 1 ENABLE: read/write.
  - 2 CLAIM: read-only, returns current interrupt_vector zero-extended.
  - 3 GIE: bit0 read/write.
- Register reads/writes: unused bits read 0. A write with sel=0 is ignored. Read data is updated only when sel & bus_read_enable, one cycle later; otherwise bus_read_data holds its value.
- FSM states: IDLE, ASSERT, DRAIN.
  - IDLE -> ASSERT when gie & |(pending & enable) & ~interrupt_ack. On that edge, interrupt_vector <= index of the lowest set bit + 1 (latched winner).
  - ASSERT: vector is held stable. Disabling enable/gie or W1C of the winner does NOT retract it. On interrupt_ack=1: clear the winner's pending (edge sources only), interrupt_vector <= 0, go to DRAIN.
  - DRAIN: wait for interrupt_ack=0, then go to IDLE. This prevents a long ack from the slow core clock re-claiming a new source.
- Latency: an edge on irq_src produces interrupt_vector != 0 SYNC_STAGES+2 cycles after the rising clk that samples it (2-stage default: 4 cycles).
- An edge arriving on the winner while in ASSERT is merged: the ack clears it. An edge arriving in DRAIN or later is kept.
- irq_pending_any is registered and updates every cycle, independent of gie.
- Reset mid-operation returns every state element to its reset value immediately; the core sees vector 0.

Decomposition:
- Shared header (header.vh, alongside Key_base/Art_base):
  - Irq_base address and register offsets IRQ_PEND=0, IRQ_EN=1, IRQ_CLAIM=2, IRQ_GIE=3.
  - FSM state encodings.
- One natural sub-module: irq_sync_edge. Per-bit synchroniser plus prev flop; outputs the synced level and the rise pulse. Generated NUM_SRC times.
- The priority encoder stays as a function inside irq_controller.

Test Plan:
- Reset, then enable=4'b0101, gie=1, 1-cycle pulse on irq_src[2] -> PENDING reads 4'b0100; vector=3 after 4 cycles; hold ack 10 cycles -> vector 0 for the whole ack, PENDING=0, no re-assert until ack falls.
- Pulse src0 and src2 in the same cycle with both enabled -> vector=1; after ack/release -> vector=3; after second ack -> idle.
- EDGE_MASK=4'b1110, src0 held high as level -> vector=1; ack -> re-asserts vector=1 after DRAIN while src0 is high; src0 low -> stays 0.
- src1 pending with enable=0 -> vector stays 0 and irq_pending_any=0; write ENABLE=2 -> vector=2; clear gie while vector=2 -> vector stays 2 until ack.
- W1C PENDING=4'b0010 in the same cycle as a new src1 edge -> PENDING bit1 stays 1.
- Assert reset while vector=2 in ASSERT -> vector=0, bus_read_data=0, all registers 0, same cycle (asynchronous).
